// File: rtl/rate_pkg.sv
// Shared defaults and elaboration helpers for the rate generator and its channels.
package rate_pkg;

    localparam int unsigned DIV_W_DEF   = 9;
    localparam int unsigned CLK_HZ_DEF  = 50_000_000;
    localparam int unsigned BASE_HZ_DEF = 128;
    localparam int unsigned MAX_PACK    = 1024;

    function automatic int unsigned calc_pre(input int unsigned clk_hz, input int unsigned base_hz);
        return clk_hz / base_hz;
    endfunction

    function automatic int unsigned pre_width(input int unsigned pre);
        return $clog2(pre);
    endfunction

    // Divisor widths are expected to stay well below 32 bits.
    function automatic int unsigned unpack_div(input logic [MAX_PACK-1:0] divs,
                                               input int unsigned         idx,
                                               input int unsigned         w);
        logic [MAX_PACK-1:0] sh;
        sh = divs >> (idx * w);
        return sh[31:0] & ((32'd1 << w) - 32'd1);
    endfunction

endpackage

// File: rtl/rate_channel.sv
// One divider channel: counts base ticks modulo div and emits an aligned strobe plus square wave.
module rate_channel
    import rate_pkg::*;
#(
    parameter int unsigned DIV_W = DIV_W_DEF
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clr,
    input  logic             adv,
    input  logic             final_wrap,
    input  logic [DIV_W-1:0] div,
    output logic             tick,
    output logic             wave,
    output logic             wrap
);

    logic [DIV_W-1:0] cnt;
    logic [DIV_W-1:0] cnt_next;
    logic [DIV_W-1:0] half;
    logic             enable;
    logic             at_end;

    always_comb begin
        enable   = (div >= DIV_W'(2));
        half     = div >> 1;
        at_end   = (cnt == div - DIV_W'(1));
        cnt_next = at_end ? '0 : cnt + DIV_W'(1);
        wrap     = adv && enable && at_end;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt  <= '0;
            tick <= 1'b0;
            wave <= 1'b0;
        end else if (clr || !enable) begin
            cnt  <= '0;
            tick <= 1'b0;
            wave <= 1'b0;
        end else begin
            tick <= wrap;
            if (adv) begin
                cnt  <= cnt_next;
                // A wrap that hands over to a disabling divisor leaves the wave low.
                wave <= (at_end && final_wrap) ? 1'b0 : (cnt_next < half);
            end
        end
    end

endmodule

// File: rtl/rate_generator.sv
// Base prescaler plus NUM_CH fixed divider channels and one runtime-programmable channel.
module rate_generator
    import rate_pkg::*;
#(
    parameter int unsigned             CLK_HZ  = CLK_HZ_DEF,
    parameter int unsigned             BASE_HZ = BASE_HZ_DEF,
    parameter int unsigned             NUM_CH  = 5,
    parameter int unsigned             DIV_W   = DIV_W_DEF,
    parameter logic [NUM_CH*DIV_W-1:0] CH_DIV  = {9'd256, 9'd128, 9'd32, 9'd16, 9'd2}
) (
    input  logic              frequency_50Mhz,
    input  logic              reset_n,
    input  logic              run,
    input  logic              sync_clr,
    input  logic [DIV_W-1:0]  prog_div,
    input  logic              prog_load,
    output logic              base_tick,
    output logic [NUM_CH-1:0] tick_o,
    output logic [NUM_CH-1:0] wave_o,
    output logic              prog_tick,
    output logic              prog_wave
);

    localparam int unsigned PRE   = calc_pre(CLK_HZ, BASE_HZ);
    localparam int unsigned PRE_W = pre_width(PRE);

    if (((CLK_HZ % BASE_HZ) != 0) || (PRE < 2)) begin : g_bad_rate
        $fatal(1, "rate_generator: CLK_HZ must be a multiple of BASE_HZ giving a prescale of at least 2");
    end

    logic [PRE_W-1:0]  pre;
    logic              tc;
    logic [DIV_W-1:0]  shadow;
    logic [DIV_W-1:0]  active;
    logic [DIV_W-1:0]  shadow_eff;
    logic              prog_off;
    logic              prog_wrap;
    logic [NUM_CH-1:0] unused_wraps;

    assign tc = run && !sync_clr && (pre == PRE_W'(PRE - 1));

    always_ff @(posedge frequency_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            pre       <= '0;
            base_tick <= 1'b0;
        end else if (sync_clr) begin
            pre       <= '0;
            base_tick <= 1'b0;
        end else begin
            base_tick <= tc;
            if (run) begin
                pre <= tc ? '0 : pre + PRE_W'(1);
            end
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam int unsigned DIV_I = unpack_div(MAX_PACK'(CH_DIV), i, DIV_W);

        if (DIV_I < 2) begin : g_bad_div
            $fatal(1, "rate_generator: every CH_DIV entry must be at least 2");
        end

        rate_channel #(.DIV_W(DIV_W)) u_ch (
            .clk        (frequency_50Mhz),
            .rst_n      (reset_n),
            .clr        (sync_clr),
            .adv        (tc),
            .final_wrap (1'b0),
            .div        (DIV_W'(DIV_I)),
            .tick       (tick_o[i]),
            .wave       (wave_o[i]),
            .wrap       (unused_wraps[i])
        );
    end

    // A load in the same cycle as a transfer is taken directly, so it is never lost.
    assign shadow_eff = prog_load ? prog_div : shadow;
    assign prog_off   = (active < DIV_W'(2));

    always_ff @(posedge frequency_50Mhz or negedge reset_n) begin
        if (!reset_n) begin
            shadow <= '0;
            active <= '0;
        end else begin
            if (prog_load) begin
                shadow <= prog_div;
            end
            if (sync_clr || prog_wrap || (prog_off && run)) begin
                active <= shadow_eff;
            end
        end
    end

    rate_channel #(.DIV_W(DIV_W)) u_prog (
        .clk        (frequency_50Mhz),
        .rst_n      (reset_n),
        .clr        (sync_clr),
        .adv        (tc),
        .final_wrap (shadow_eff < DIV_W'(2)),
        .div        (active),
        .tick       (prog_tick),
        .wave       (prog_wave),
        .wrap       (prog_wrap)
    );

endmodule
